pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit_if.sv | 33 +++
 rtl/pc_fetch_unit.sv | 106 ++++++++++
 tb/tb_pc_fetch_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus between the hazard/branch logic and the PC unit.
// The misalign_fault signal exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_fetch_unit_if #(
  parameter int unsigned WIDTH = 64
);
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             halt;
  logic [WIDTH-1:0] pc;
  logic             fetch_valid;
  logic             flush_if_id;
  logic             halted;
`ifdef PC_ALIGN_CHECK_EN
  logic             misalign_fault;
`endif

  modport master (
    output stall, br_taken, br_target, halt,
    input  pc, fetch_valid, flush_if_id, halted
`ifdef PC_ALIGN_CHECK_EN
    , misalign_fault
`endif
  );

  modport slave (
    input  stall, br_taken, br_target, halt,
    output pc, fetch_valid, flush_if_id, halted
`ifdef PC_ALIGN_CHECK_EN
    , misalign_fault
`endif
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: registered next-PC select with stall, redirect, halt and boot sequencing.
// Optional PC_ALIGN_CHECK_EN halts on a misaligned taken-branch target and raises misalign_fault.
module pc_fetch_unit #(
  parameter int unsigned      WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      INC      = 4,
  parameter real              DELAY    = 0.05
) (
  input logic            clk,
  input logic            reset_n,
  pc_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             fetch_valid_q;
  logic             flush_q;
  logic             halted_q;
  logic [WIDTH-1:0] pc_inc_c;
  logic [WIDTH-1:0] pc_d;
  logic             misalign_c;

  // DELAY only annotates gate-level netlists; the synthesized select carries no delay.
  if (DELAY < 0.0) begin : g_neg_delay
  end

  assign pc_inc_c = pc_q + WIDTH'(INC);

  // Per-bit 2:1 select: br_taken picks the target over the sequential address.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_sel
    assign pc_d[i] = bus.br_taken ? bus.br_target[i] : pc_inc_c[i];
  end

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;
  assign misalign_c          = (bus.br_target[1:0] != 2'b00);
  assign bus.misalign_fault  = fault_q;
`else
  assign misalign_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN, STALL: begin
          if (bus.halt) begin
            state_q       <= HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
          end else if (bus.br_taken) begin
            flush_q <= 1'b1;
            if (misalign_c) begin
              state_q       <= HALT;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
              fault_q       <= 1'b1;
`endif
            end else begin
              state_q <= RUN;
              pc_q    <= pc_d;
            end
          end else if (bus.stall) begin
            state_q <= STALL;
          end else begin
            state_q <= RUN;
            pc_q    <= pc_d;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush_if_id = flush_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then randomized traffic vs a behavioural model.
module tb_pc_fetch_unit;

  localparam int unsigned WIDTH    = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int unsigned INC      = 4;

  typedef struct {
    logic [63:0] pc;
    logic        fv;
    logic        fl;
    logic        ht;
    logic        mf;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  // behavioural model state
  logic [63:0] m_pc;
  bit          m_boot;
  bit          m_halted;
  bit          m_flush;
  bit          m_fault;

  pc_fetch_unit_if #(.WIDTH(WIDTH)) bus ();

  pc_fetch_unit #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC),
    .INC     (INC),
    .DELAY   (0.05)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the coming edge, queue the expectation.
  task automatic step(input bit rst, input bit st, input bit br, input logic [63:0] tgt, input bit hl);
    exp_t e;
    @(negedge clk);
    reset_n       = ~rst;
    bus.stall     = st;
    bus.br_taken  = br;
    bus.br_target = tgt;
    bus.halt      = hl;
    m_flush = 1'b0;
    if (rst) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_halted = 1'b0; m_fault = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (hl) begin
      m_halted = 1'b1;
    end else if (br) begin
      m_flush = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        m_halted = 1'b1; m_fault = 1'b1;
      end else
`endif
      m_pc = tgt;
    end else if (!st) begin
      m_pc = m_pc + 64'(INC);
    end
    e.pc = m_pc;
    e.fv = !m_boot && !m_halted;
    e.fl = m_flush;
    e.ht = m_halted;
    e.mf = m_fault;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents its registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", bus.pc, e.pc);
        chk("fetch_valid", 64'(bus.fetch_valid), 64'(e.fv));
        chk("flush_if_id", 64'(bus.flush_if_id), 64'(e.fl));
        chk("halted", 64'(bus.halted), 64'(e.ht));
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign_fault", 64'(bus.misalign_fault), 64'(e.mf));
`endif
      end
    end
  end

  initial begin
    logic [63:0] tgt;
    checks = 0;
    errors = 0;
    m_pc = '0; m_boot = 1'b1; m_halted = 1'b0; m_flush = 1'b0; m_fault = 1'b0;
    reset_n = 1'b0; bus.stall = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0; bus.halt = 1'b0;

    // reset then free run from RESET_PC
    step(1, 0, 0, 64'h0, 0);
    step(1, 0, 0, 64'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 64'h0, 0);
    // stall at 0x10 for three cycles
    step(0, 0, 1, 64'h10, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h0, 0);
    step(0, 0, 0, 64'h0, 0);
    step(0, 0, 0, 64'h0, 0);
    // redirect wins over a stall, then back-to-back branches
    step(0, 0, 1, 64'h20, 0);
    step(0, 1, 1, 64'h100, 0);
    step(0, 0, 0, 64'h0, 0);
    step(0, 0, 1, 64'h200, 0);
    step(0, 0, 1, 64'h300, 0);
    step(0, 0, 0, 64'h0, 0);
    // wrap at the top of the address space
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    step(0, 0, 0, 64'h0, 0);
    step(0, 0, 0, 64'h0, 0);
    // halt ignores branches; reset recovers
    step(0, 0, 1, 64'h40, 0);
    step(0, 0, 0, 64'h0, 1);
    step(0, 0, 1, 64'h500, 0);
    step(0, 1, 1, 64'h600, 1);
    step(1, 0, 0, 64'h0, 0);
    step(0, 0, 0, 64'h0, 0);
    step(0, 0, 0, 64'h0, 0);
`ifdef PC_ALIGN_CHECK_EN
    step(0, 0, 1, 64'h102, 0);
    step(0, 0, 0, 64'h0, 0);
    step(1, 0, 0, 64'h0, 0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 9) < 8) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | (tgt & 64'hC);
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 15,
           tgt,
           $urandom_range(0, 99) < 2);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
